// File: rtl/anim_pkg.sv
// Shared constants for the LED animation engine: pattern mode codes and
// the sweep direction used by the bounce and fill patterns.
package anim_pkg;

  localparam logic [1:0] MODE_WALK_L = 2'd0;
  localparam logic [1:0] MODE_WALK_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/anim_prescaler.sv
// Step prescaler: counts enabled cycles and fires a one-cycle tick once the
// count reaches div, giving a step period of div+1 cycles. The >= compare
// means lowering div below the running count ticks on the very next cycle.
module anim_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Tick decode and counter next value; disabling clears the count so a
  // re-enable always waits a full period before the first step.
  always_comb begin
    tick  = en && (cnt_q >= div);
    cnt_d = cnt_q + DIV_W'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_anim_seq.sv
// LED animation engine: four patterns (walk-left, walk-right, bounce,
// fill/drain) advanced on prescaler ticks. A mode request is only taken on
// a tick, where it restarts the new pattern instead of advancing, so the
// LEDs never glitch between steps.
// Optional build macro LED_ANIM_PWM_EN adds a bright[3:0] input and a
// free-running 4-bit PWM counter that gates the output for dimming.
module led_anim_seq
  import anim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
`ifdef LED_ANIM_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [WIDTH-1:0] out,
  output logic [1:0]       mode_act,
  output logic             step
);

  localparam logic [WIDTH-1:0] PAT_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAT_MSB = PAT_LSB << (WIDTH - 1);

  logic             tick;
  logic [WIDTH-1:0] pat_q, pat_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       mode_act_q, mode_act_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             step_q, step_d;

  anim_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .div  (div),
    .tick (tick)
  );

`ifdef LED_ANIM_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  // Free-running PWM phase counter, independent of en.
  always_comb pwm_cnt_d = pwm_cnt_q + 4'd1;

  // PWM counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  // Pattern state register (pattern, sweep direction, active mode).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q      <= PAT_LSB;
      dir_q      <= DIR_UP;
      mode_act_q <= MODE_WALK_L;
    end else begin
      pat_q      <= pat_d;
      dir_q      <= dir_d;
      mode_act_q <= mode_act_d;
    end
  end

  // Next pattern: on a tick either restart a newly requested mode or
  // advance the active one; between ticks everything holds.
  always_comb begin
    pat_d      = pat_q;
    dir_d      = dir_q;
    mode_act_d = mode_act_q;
    if (tick) begin
      if (mode != mode_act_q) begin
        mode_act_d = mode;
        dir_d      = DIR_UP;
        pat_d      = (mode == MODE_WALK_R) ? PAT_MSB : PAT_LSB;
      end else begin
        unique case (mode_act_q)
          MODE_WALK_L: pat_d = (pat_q << 1) | (pat_q >> (WIDTH - 1));
          MODE_WALK_R: pat_d = (pat_q >> 1) | (pat_q << (WIDTH - 1));
          MODE_BOUNCE: begin
            // Turn around on reaching an end so each endpoint shows once;
            // a single LED has nowhere to go and just stays lit.
            if (WIDTH == 1) begin
              pat_d = pat_q;
            end else if (dir_q == DIR_UP) begin
              if (pat_q[WIDTH-1]) begin
                dir_d = DIR_DN;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = DIR_UP;
                pat_d = pat_q << 1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          MODE_FILL: begin
            // Fill to all-ones, drain down to zero, then refill from 1.
            if (dir_q == DIR_UP) begin
              if (&pat_q) begin
                dir_d = DIR_DN;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = (pat_q << 1) | PAT_LSB;
              end
            end else begin
              if (pat_q == '0) begin
                dir_d = DIR_UP;
                pat_d = PAT_LSB;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          default: pat_d = pat_q;
        endcase
      end
    end
  end

  // Output drive: registered copy of the pattern while enabled, dark
  // otherwise; step mirrors the tick one cycle later.
  always_comb begin
    step_d = tick;
`ifdef LED_ANIM_PWM_EN
    out_d  = (en && (pwm_cnt_q < bright)) ? pat_q : '0;
`else
    out_d  = en ? pat_q : '0;
`endif
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      step_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      step_q <= step_d;
    end
  end

  assign out      = out_q;
  assign mode_act = mode_act_q;
  assign step     = step_q;

endmodule

// File: tb/tb_led_anim_seq.sv
// Bench for led_anim_seq: an 8-wide and a 4-wide instance share all inputs
// and are compared every cycle against a step-index reference model.
module tb_led_anim_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] div = 24'd0;
`ifdef LED_ANIM_PWM_EN
  logic [3:0]  bright = 4'd15;
`endif
  logic [7:0]  out8;
  logic [3:0]  out4;
  logic [1:0]  ma8, ma4;
  logic        step8, step4;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int m_mode = 0;   // active mode
  int m_k = 0;      // number of advances since the active mode started
  int m_cnt = 0;    // enabled cycles since last step
  int m_pwm = 0;
  logic [31:0] exp_out8, exp_out4;
  logic exp_step;

  always #5 clk = ~clk;

  led_anim_seq #(.WIDTH(8), .DIV_W(24)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
`ifdef LED_ANIM_PWM_EN
    .bright(bright),
`endif
    .out(out8), .mode_act(ma8), .step(step8)
  );

  led_anim_seq #(.WIDTH(4), .DIV_W(24)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
`ifdef LED_ANIM_PWM_EN
    .bright(bright),
`endif
    .out(out4), .mode_act(ma4), .step(step4)
  );

  // Pattern after k advances from the start of mode md, for a w-bit display.
  function automatic logic [31:0] pat_ref(int w, int md, int k);
    int p, n;
    case (md)
      0: return 32'd1 << (k % w);
      1: return 32'd1 << (w - 1 - (k % w));
      2: begin
        if (w == 1) return 32'd1;
        p = k % (2 * w - 2);
        return 32'd1 << ((p < w) ? p : (2 * w - 2 - p));
      end
      default: begin
        p = k % (2 * w);
        n = (p < w) ? p + 1 : 2 * w - 1 - p;
        return (32'd1 << n) - 32'd1;
      end
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_cnt = 0; m_pwm = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all DUT outputs 1 time unit later.
  task automatic cycle();
    logic tk;
    @(posedge clk);
    exp_out8 = en ? pat_ref(8, m_mode, m_k) : 32'd0;
    exp_out4 = en ? pat_ref(4, m_mode, m_k) : 32'd0;
`ifdef LED_ANIM_PWM_EN
    if (!(m_pwm < int'(bright))) begin
      exp_out8 = 32'd0;
      exp_out4 = 32'd0;
    end
    m_pwm = (m_pwm + 1) % 16;
`endif
    tk = en && (m_cnt >= int'(div));
    m_cnt = (!en || tk) ? 0 : m_cnt + 1;
    exp_step = tk;
    if (tk) begin
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_k = 0;
      end else begin
        m_k++;
      end
    end
    #1;
    check("out8", 32'(out8), exp_out8);
    check("out4", 32'(out4), exp_out4);
    check("step8", 32'(step8), 32'(exp_step));
    check("mode_act8", 32'(ma8), 32'(m_mode));
  endtask

  // Async reset pulse launched between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out8", 32'(out8), 32'd0);
    check("rst_mode_act8", 32'(ma8), 32'd0);
    check("rst_step8", 32'(step8), 32'd0);
    check("rst_out4", 32'(out4), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [23:0] div;
    logic [7:0] out;
    logic       step;
    logic [1:0] ma;
  } vec_t;

  vec_t tbl[11];

  initial begin : main
    logic [3:0] prev4;
    bit seen;

    // walk-left at full speed, then an enable drop and resume
    tbl[0]  = '{1'b1, 2'd0, 24'd0, 8'h01, 1'b1, 2'd0};
    tbl[1]  = '{1'b1, 2'd0, 24'd0, 8'h02, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 2'd0, 24'd0, 8'h04, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 2'd0, 24'd0, 8'h08, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 24'd0, 8'h10, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 2'd0, 24'd0, 8'h20, 1'b1, 2'd0};
    tbl[6]  = '{1'b1, 2'd0, 24'd0, 8'h40, 1'b1, 2'd0};
    tbl[7]  = '{1'b1, 2'd0, 24'd0, 8'h80, 1'b1, 2'd0};
    tbl[8]  = '{1'b1, 2'd0, 24'd0, 8'h01, 1'b1, 2'd0};
    tbl[9]  = '{1'b0, 2'd0, 24'd0, 8'h00, 1'b0, 2'd0};
    tbl[10] = '{1'b1, 2'd0, 24'd0, 8'h02, 1'b1, 2'd0};

    #12;
    check("reset_out8", 32'(out8), 32'd0);
    check("reset_mode_act8", 32'(ma8), 32'd0);
    check("reset_step8", 32'(step8), 32'd0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; div = tbl[i].div;
      cycle();
`ifndef LED_ANIM_PWM_EN
      check($sformatf("tbl%0d_out", i), 32'(out8), 32'(tbl[i].out));
`endif
      check($sformatf("tbl%0d_step", i), 32'(step8), 32'(tbl[i].step));
      check($sformatf("tbl%0d_ma", i), 32'(ma8), 32'(tbl[i].ma));
    end

    // bounce at div=3: first tick only switches mode
    en = 1'b0;
    do_reset();
    en = 1'b1; mode = 2'd2; div = 24'd3;
    for (int i = 0; i < 4; i++) cycle();
    check("bounce_mode_act", 32'(ma8), 32'd2);
    for (int i = 0; i < 70; i++) cycle();

    // fill, then a mid-count switch to walk-right
    do_reset();
    mode = 2'd3;
    for (int i = 0; i < 42; i++) cycle();
    mode = 2'd1;
    prev4 = out4;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (out4 != prev4) seen = 1'b1;
    end
`ifndef LED_ANIM_PWM_EN
    check("switch_seen", 32'(seen), 32'd1);
    check("switch_out4", 32'(out4), 32'h8);
`endif
    for (int i = 0; i < 10; i++) cycle();

    // enable drop mid-run and resume
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    en = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // async reset with 0x10 showing, then restart from 01
    mode = 2'd0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (exp_out8 == 32'h10) seen = 1'b1;
    end
    check("reach_10", 32'(seen), 32'd1);
    do_reset();
    cycle();
`ifndef LED_ANIM_PWM_EN
    check("restart_01", 32'(out8), 32'h01);
`endif

`ifdef LED_ANIM_PWM_EN
    div = 24'd1000;
    bright = 4'd4;
    for (int i = 0; i < 48; i++) cycle();
    bright = 4'd0;
    for (int i = 0; i < 32; i++) cycle();
    bright = 4'd15;
`endif

    // randomized run
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 200 == 0) do_reset();
      en = ($urandom % 8) != 0;
      if ($urandom % 25 == 0) mode = 2'($urandom % 4);
      if ($urandom % 30 == 0) div = 24'($urandom % 6);
`ifdef LED_ANIM_PWM_EN
      if ($urandom % 40 == 0) bright = 4'($urandom % 16);
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
